// File: rtl/cache_miss_handler.sv
// Miss sequencer between the 4-way data cache and data memory: optional dirty
// writeback, then a word fetch for loads, with saturating miss/writeback counters.
module cache_miss_handler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cache_hit,
    input  logic              victim_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [DATA_W-1:0] victim_data,
    output logic              stall,
    output logic              fill_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WB   = 2'd1;
    localparam logic [1:0] FILL = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  miss_q, miss_d;
    logic [CNT_W-1:0]  wbc_q, wbc_d;
    logic              miss;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign miss = (state_q == IDLE) & cpu_valid & ~cache_hit;

    // The miss cycle itself is stalled combinationally so the CPU never advances past it.
    assign stall      = (state_q != IDLE) | miss;
    assign fill_valid = (state_q == DONE) & ~wr_q;
    assign fill_data  = fill_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign miss_cnt   = miss_q;
    assign wb_cnt     = wbc_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        fill_d  = fill_q;
        caddr_d = caddr_q;
        wr_d    = wr_q;
        miss_d  = miss_q;
        wbc_d   = wbc_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    caddr_d = cpu_addr & ALIGN_MASK;
                    wr_d    = cpu_write;
                    miss_d  = sat_inc(miss_q);
                    // The victim is captured straight into the request registers.
                    if (victim_dirty) begin
                        state_d = WB;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        maddr_d = victim_addr;
                        wdata_d = victim_data;
                    end else if (!cpu_write) begin
                        state_d = FILL;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        maddr_d = cpu_addr & ALIGN_MASK;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    wbc_d = sat_inc(wbc_q);
                    we_d  = 1'b0;
                    if (!wr_q) begin
                        state_d = FILL;
                        maddr_d = caddr_q;
                    end else begin
                        state_d = DONE;
                        req_d   = 1'b0;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    fill_d  = mem_rdata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            fill_q  <= '0;
            caddr_q <= '0;
            wr_q    <= 1'b0;
            miss_q  <= '0;
            wbc_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            fill_q  <= fill_d;
            caddr_q <= caddr_d;
            wr_q    <= wr_d;
            miss_q  <= miss_d;
            wbc_q   <= wbc_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Randomized bench for cache_miss_handler: a transaction-level model predicts the
// memory accesses, stall length, fill and counters for every miss.
module tb_cache_miss_handler;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_valid = 1'b0, cpu_write = 1'b0, cache_hit = 1'b0, victim_dirty = 1'b0;
    logic [AW-1:0] cpu_addr = '0, victim_addr = '0;
    logic [DW-1:0] victim_data = '0;
    logic          stall, fill_valid, mem_req, mem_we;
    logic [DW-1:0] fill_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic [CW-1:0] miss_cnt, wb_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int m_miss = 0;
    int m_wb = 0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    cache_miss_handler #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cache_hit(cache_hit), .victim_dirty(victim_dirty),
        .victim_addr(victim_addr), .victim_data(victim_data), .stall(stall),
        .fill_valid(fill_valid), .fill_data(fill_data), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete miss; memory answers every request after w wait cycles.
    task automatic run_miss(input logic wr, input logic dirty, input logic [AW-1:0] addr,
                            input logic [AW-1:0] vaddr, input logic [DW-1:0] vdata,
                            input logic [DW-1:0] rdata, input int w);
        txn_t exp_q[$];
        txn_t obs_q[$];
        txn_t cur;
        int stall_n = 0;
        int fills = 0;
        int wcnt = 0;
        int exp_stall;
        logic [DW-1:0] got_fill = '0;
        bit done = 0;
        cur = '0;
        if (dirty) exp_q.push_back('{1'b1, vaddr, vdata});
        if (!wr) exp_q.push_back('{1'b0, addr & ~32'h3, 32'h0});
        exp_stall = 2 + (dirty ? w + 1 : 0) + (wr ? 0 : w + 1);
        @(negedge clk);
        cpu_valid = 1'b1; cpu_write = wr; cpu_addr = addr; cache_hit = 1'b0;
        victim_dirty = dirty; victim_addr = vaddr; victim_data = vdata; mem_ready = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            if (!stall) begin
                done = 1;
            end else begin
                stall_n++;
                if (fill_valid) begin
                    fills++;
                    got_fill = fill_data;
                end
                if (mem_req) begin
                    if (wcnt == 0) begin
                        cur = '{mem_we, mem_addr, mem_we ? mem_wdata : '0};
                    end else begin
                        chk("hold_we", mem_we, cur.we);
                        chk("hold_addr", mem_addr, cur.a);
                        if (cur.we) chk("hold_wdata", mem_wdata, cur.d);
                    end
                    if (wcnt == w) begin
                        mem_ready = 1'b1;
                        mem_rdata = mem_we ? $urandom : rdata;
                        obs_q.push_back(cur);
                        wcnt = 0;
                    end else begin
                        mem_ready = 1'b0;
                        mem_rdata = $urandom;
                        wcnt++;
                    end
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                    wcnt = 0;
                end
                @(negedge clk);
                cpu_addr = $urandom; victim_addr = $urandom; victim_data = $urandom;
                cpu_write = 1'($urandom); victim_dirty = 1'($urandom);
                cpu_valid = 1'($urandom); cache_hit = 1'b1;
            end
        end
        mem_ready = 1'b0;
        chk("timeout", done, 1);
        if (m_miss < 15) m_miss++;
        if (dirty && m_wb < 15) m_wb++;
        chk("stall_len", stall_n, exp_stall);
        chk("fill_pulses", fills, wr ? 0 : 1);
        if (!wr) chk("fill_data", got_fill, rdata);
        chk("txn_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk("txn_we", obs_q[i].we, exp_q[i].we);
            chk("txn_addr", obs_q[i].a, exp_q[i].a);
            if (exp_q[i].we) chk("txn_wdata", obs_q[i].d, exp_q[i].d);
        end
        chk("miss_cnt", miss_cnt, m_miss);
        chk("wb_cnt", wb_cnt, m_wb);
    endtask

    initial begin
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_fill_data", fill_data, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_wb_cnt", wb_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_miss(1'b0, 1'b0, 32'h0000_0104, 32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 2);
        run_miss(1'b0, 1'b1, 32'h0000_0804, 32'h0000_0404, 32'h1234_5678, 32'hCAFE_F00D, 0);
        run_miss(1'b1, 1'b1, 32'h0000_0A08, 32'h0000_0C00, 32'h5A5A_A5A5, 32'h0, 10);
        run_miss(1'b1, 1'b0, 32'h0000_0F0F, 32'h0000_0E00, 32'h0, 32'h0, 0);
        run_miss(1'b0, 1'b0, 32'h0000_1003, 32'h0000_2000, 32'h0, 32'h0BAD_F00D, 0);

        for (int i = 0; i < 25; i++) begin
            run_miss(1'($urandom), 1'($urandom), $urandom, $urandom & ~32'h3,
                     $urandom, $urandom, $urandom_range(0, 4));
        end

        // Reset landing mid-FILL.
        @(negedge clk);
        cpu_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0500; cache_hit = 1'b0;
        victim_dirty = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        cache_hit = 1'b1;
        #1;
        chk("fill_req", mem_req, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", mem_req, 0);
        chk("async_stall", stall, 0);
        chk("async_miss_cnt", miss_cnt, 0);
        chk("async_wb_cnt", wb_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_miss = 0;
        m_wb = 0;
        #1;
        chk("post_rst_stall", stall, 0);
        @(negedge clk);
        #1;
        chk("post_rst_req", mem_req, 0);
        chk("post_rst_hit_stall", stall, 0);

        for (int i = 0; i < 20; i++) begin
            run_miss(1'($urandom), 1'($urandom), $urandom, $urandom & ~32'h3,
                     $urandom, $urandom, $urandom_range(0, 2));
        end
        chk("miss_cnt_sat", miss_cnt, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
